// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: data-memory req/ack bus between the MEM-stage
// sequencer (master) and the wait-stated data memory (slave).
interface mem_stage_ctrl_if #(
   parameter int MAX_LENGTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [MAX_LENGTH-1:0] mem_addr;
   logic [MAX_LENGTH-1:0] mem_wdata;
   logic [MAX_LENGTH-1:0] mem_rdata;
   logic                  mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory sequencer with pipeline freeze.
// Define MEM_TIMEOUT_EN for a WAIT watchdog and a sticky mem_error flag.
module mem_stage_ctrl #(
   parameter int MAX_LENGTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_read_enabled,
   input  logic                  memory_write_enabled,
   input  logic [MAX_LENGTH-1:0] address,
   input  logic [MAX_LENGTH-1:0] write_value,
   output logic                  freeze,
   output logic [MAX_LENGTH-1:0] mem_read_value,
   output logic                  mem_error,
   mem_stage_ctrl_if.master      bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [MAX_LENGTH-1:0] addr_q, addr_d;
   logic [MAX_LENGTH-1:0] wdata_q, wdata_d;
   logic [MAX_LENGTH-1:0] rval_q, rval_d;
   logic                  mem_op;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("TIMEOUT must be at least 1");
   end

   assign mem_op = memory_read_enabled | memory_write_enabled;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   // next-state, latch and capture logic for the access sequencer
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rval_d  = rval_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               addr_d  = address;
               wdata_d = write_value;
               we_d    = memory_write_enabled;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (bus.mem_ack) begin
               if (!we_q) rval_d = bus.mem_rdata;
               state_d = S_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               if (!we_q) rval_d = '0;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      req_d = (state_d == S_WAIT);
   end

   // state and latched bus registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rval_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rval_q  <= rval_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // WAIT watchdog counter and sticky timeout flag
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_error = err_q;
`else
   assign mem_error = 1'b0;
`endif

   assign freeze = ((state_q == S_IDLE) && mem_op)
                 || (state_q == S_ISSUE)
                 || (state_q == S_WAIT);

   assign mem_read_value = rval_q;
   assign bus.mem_req    = req_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: vector table, hand sequences and a random
// transaction stream checked against a transaction-level model.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 1 << 30;
`endif
   localparam bit ST_TMO = (4 >= TO);

   logic        clk;
   logic        rst;
   logic        rei;
   logic        wei;
   logic [31:0] addr;
   logic [31:0] wval;
   logic        freeze;
   logic [31:0] rv;
   logic        err;

   int n_tests;
   int n_fail;

   logic [31:0] m_rv;
   logic        m_err;

   mem_stage_ctrl_if #(.MAX_LENGTH(32)) bus ();

   mem_stage_ctrl #(
      .MAX_LENGTH(32),
      .TIMEOUT   (4)
   ) dut (
      .clk                 (clk),
      .reset               (rst),
      .memory_read_enabled (rei),
      .memory_write_enabled(wei),
      .address             (addr),
      .write_value         (wval),
      .freeze              (freeze),
      .mem_read_value      (rv),
      .mem_error           (err),
      .bus                 (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        re;
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          dly;
      logic        xwe;
      int          xfz;
      logic [31:0] xrv;
      logic        xerr;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rei = 1'b0;
      wei = 1'b0;
      bus.mem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // One access: dly = WAIT cycles without ack before the acked one.
   task automatic run_op(input logic re, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly,
                         input logic xwe, input int xfz,
                         input logic [31:0] xrv, input logic xerr);
      int fz;
      int reqc;
      int wc;
      bit done;
      bit stable;
      @(negedge clk);
      rei = re;
      wei = we;
      addr = a;
      wval = wd;
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      #1;
      if (!re && !we) begin
         chk("nop_freeze", {31'b0, freeze}, 32'd0);
         chk("nop_req", {31'b0, bus.mem_req}, 32'd0);
         chk("nop_rval", rv, xrv);
         chk("nop_err", {31'b0, err}, {31'b0, xerr});
         @(posedge clk);
         return;
      end
      fz = freeze ? 1 : 0;
      reqc = 0;
      wc = 0;
      done = 0;
      stable = 1;
      @(posedge clk);
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         rei = 1'($urandom_range(0, 1));
         wei = 1'($urandom_range(0, 1));
         addr = $urandom;
         wval = $urandom;
         #1;
         if (bus.mem_req) begin
            reqc++;
            if (bus.mem_addr !== a || bus.mem_wdata !== wd
                || bus.mem_we !== xwe)
               stable = 0;
            bus.mem_ack = (wc == dly);
            bus.mem_rdata = (wc == dly) ? rd : $urandom;
            wc++;
         end else begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
         end
         if (freeze) begin
            fz++;
         end else begin
            done = 1;
            chk("done_rval", rv, xrv);
            chk("done_err", {31'b0, err}, {31'b0, xerr});
            chk("done_we", {31'b0, bus.mem_we}, {31'b0, xwe});
         end
         @(posedge clk);
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL op_budget: no unfrozen cycle within 300 cycles");
      end
      chk("freeze_cycles", fz, xfz);
      chk("req_cycles", reqc, xfz - 2);
      chk("bus_stable", {31'b0, stable}, 32'd1);
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1);
   end

   initial begin
      int r;
      int dly;
      int xfz;
      int cnt;
      logic re;
      logic we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;

      n_tests = 0;
      n_fail = 0;

      tbl[0] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0,
                 1'b0, 3, 32'hDEADBEEF, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 32'h11111111, 1,
                 1'b1, 4, 32'hDEADBEEF, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 2,
                 1'b0, 5, 32'hCAFEF00D, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 32'h104, 32'h0, 32'h0BADC0DE, 0,
                 1'b0, 3, 32'h0BADC0DE, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 32'h108, 32'h9, 32'h0, 0,
                 1'b0, 0, 32'h0BADC0DE, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 32'h10C, 32'h0, 32'h13579BDF, 3,
                 1'b0, 6, 32'h13579BDF, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 32'h80, 32'h12345678, 32'h0, 4,
                 1'b1, ST_TMO ? TO + 2 : 7, 32'h13579BDF, ST_TMO};

      rst = 1'b1;
      rei = 1'b0;
      wei = 1'b0;
      addr = 32'h0;
      wval = 32'h0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
      chk("rst_we", {31'b0, bus.mem_we}, 32'd0);
      chk("rst_addr", bus.mem_addr, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_rval", rv, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_freeze_idle", {31'b0, freeze}, 32'd0);
      rei = 1'b1;
      #1;
      chk("rst_freeze_req", {31'b0, freeze}, 32'd1);
      rei = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_op(tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].rd,
                tbl[i].dly, tbl[i].xwe, tbl[i].xfz, tbl[i].xrv,
                tbl[i].xerr);

      // reset while WAIT is pending, then stray acks
      @(negedge clk);
      rei = 1'b1;
      wei = 1'b0;
      addr = 32'h200;
      wval = 32'h77;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      rei = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_req_before", {31'b0, bus.mem_req}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_req", {31'b0, bus.mem_req}, 32'd0);
      chk("mid_freeze", {31'b0, freeze}, 32'd0);
      chk("mid_addr", bus.mem_addr, 32'd0);
      chk("mid_wdata", bus.mem_wdata, 32'd0);
      chk("mid_rval", rv, 32'd0);
      chk("mid_err", {31'b0, err}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.mem_ack = 1'b1;
         bus.mem_rdata = 32'hFFFFFFFF;
         @(negedge clk);
         #1;
         chk("late_ack_freeze", {31'b0, freeze}, 32'd0);
         chk("late_ack_rval", rv, 32'd0);
      end
      bus.mem_ack = 1'b0;
      m_rv = 32'h0;
      m_err = 1'b0;

`ifdef MEM_TIMEOUT_EN
      run_op(1'b1, 1'b0, 32'h2A0, 32'h0, 32'h2468ACE0, 0,
             1'b0, 3, 32'h2468ACE0, 1'b0);
      run_op(1'b1, 1'b0, 32'h300, 32'h0, 32'h55AA55AA, 100,
             1'b0, TO + 2, 32'h0, 1'b1);
      run_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0,
             1'b0, 0, 32'h0, 1'b1);
      run_op(1'b0, 1'b1, 32'h304, 32'h5, 32'h0, 0,
             1'b1, 3, 32'h0, 1'b1);
      do_reset();
      chk("tmo_err_cleared", {31'b0, err}, 32'd0);
`else
      @(negedge clk);
      rei = 1'b1;
      wei = 1'b0;
      addr = 32'h300;
      bus.mem_ack = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         rei = 1'b0;
         #1;
         if (freeze && bus.mem_req) cnt++;
      end
      chk("no_tmo_hold", cnt, 39);
      chk("no_tmo_err", {31'b0, err}, 32'd0);
      do_reset();
      chk("no_tmo_rst_freeze", {31'b0, freeze}, 32'd0);
`endif

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 7);
         re = (r != 0) && (r[0] || r[2]);
         we = (r != 0) && r[1];
         dly = $urandom_range(0, 6);
         a = $urandom;
         wd = $urandom;
         rd = $urandom;
         xfz = 0;
         if (re || we) begin
            if (dly >= TO) begin
               xfz = TO + 2;
               m_err = 1'b1;
               if (!we) m_rv = 32'h0;
            end else begin
               xfz = dly + 3;
               if (!we) m_rv = rd;
            end
         end
         run_op(re, we, a, wd, rd, dly, we, xfz, m_rv, m_err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
